// File: rtl/snd_pkg.sv
// rtl/snd_pkg.sv - shared register map, ctrl bits and period scaling for the sound bank
package snd_pkg;

  localparam logic [15:0] CH_STRIDE = 16'h1000;
  localparam logic [15:0] REG_SPAN  = 16'd3;
  localparam logic [15:0] CTRL_OFF  = 16'h0003;

  localparam logic [1:0] REG0_OFF = 2'd0;
  localparam logic [1:0] REG1_OFF = 2'd1;
  localparam logic [1:0] REG2_OFF = 2'd2;

  localparam int CTRL_HALT   = 0;
  localparam int CTRL_SHIFT4 = 1;
  localparam int CTRL_SHIFT8 = 2;

  localparam logic [2:0] SAW_STEP_WRAP = 3'd6;

  function automatic logic [11:0] eff_period(input logic [11:0] period,
                                             input logic shift4,
                                             input logic shift8);
    if (shift8)      return period >> 8;
    else if (shift4) return period >> 4;
    else             return period;
  endfunction

endpackage

// File: rtl/snd_pulse_ch.sv
// rtl/snd_pulse_ch.sv - one pulse channel: registers, 12-bit divider, 16-step duty sequencer
module snd_pulse_ch
  import snd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       halt_i,
  input  logic       shift4_i,
  input  logic       shift8_i,
  input  logic       wr_i,
  input  logic [1:0] off_i,
  input  logic [7:0] data_i,
  output logic [3:0] level_o
);

  logic        mode_q, mode_d;
  logic [2:0]  duty_q, duty_d;
  logic [3:0]  vol_q, vol_d;
  logic [11:0] period_q, period_d;
  logic        en_q, en_d;
  logic [11:0] div_q, div_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  level_q, level_d;

  always_comb begin
    mode_d   = mode_q;
    duty_d   = duty_q;
    vol_d    = vol_q;
    period_d = period_q;
    en_d     = en_q;
    div_d    = div_q;
    step_d   = step_q;
    if (wr_i) begin
      case (off_i)
        REG0_OFF: {mode_d, duty_d, vol_d} = data_i;
        REG1_OFF: period_d[7:0] = data_i;
        REG2_OFF: begin
          period_d[11:8] = data_i[3:0];
          en_d           = data_i[7];
        end
        default: ;
      endcase
    end
    // A disabled channel sits at step 0 with its divider preloaded, so enabling starts a full step 0.
    if (!en_q || !en_d) begin
      div_d  = eff_period(period_d, shift4_i, shift8_i);
      step_d = '0;
    end else if (!halt_i) begin
      if (div_q == '0) begin
        div_d  = eff_period(period_q, shift4_i, shift8_i);
        step_d = step_q + 4'd1;
      end else begin
        div_d = div_q - 12'd1;
      end
    end
    level_d = (en_q && (mode_q || (step_q <= {1'b0, duty_q}))) ? vol_q : '0;
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      mode_q   <= 1'b0;
      duty_q   <= '0;
      vol_q    <= '0;
      period_q <= '0;
      en_q     <= 1'b0;
      div_q    <= '0;
      step_q   <= '0;
      level_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      vol_q    <= vol_d;
      period_q <= period_d;
      en_q     <= en_d;
      div_q    <= div_d;
      step_q   <= step_d;
      level_q  <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/snd_pulse_bank.sv
// rtl/snd_pulse_bank.sv - pulse channel bank, optional sawtooth and saturating mixer on falling cpu_m2
module snd_pulse_bank
  import snd_pkg::*;
#(
  parameter int          NUM_PULSE = 2,
  parameter int          SAW_EN    = 1,
  parameter logic [15:0] BASE_ADDR = 16'h9000,
  parameter int          OUT_W     = 7
) (
  input  logic             cpu_m2,
  input  logic             rst,
  input  logic             cpu_rw,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_data,
  output logic [OUT_W-1:0] snd_vol
);

  localparam int          SUM_W    = $clog2(NUM_PULSE * 15 + 32);
  localparam logic [31:0] VOL_MAX  = (32'd1 << OUT_W) - 32'd1;
  localparam logic [15:0] SAW_BASE = BASE_ADDR + 16'(NUM_PULSE) * CH_STRIDE;

  logic [2:0]       ctrl_q, ctrl_d;
  logic [OUT_W-1:0] vol_q, vol_d;
  logic [3:0]       pulse_level [NUM_PULSE];
  logic [4:0]       saw_level;
  logic [SUM_W-1:0] sum;

  always_comb begin
    ctrl_d = ctrl_q;
    if (!cpu_rw && cpu_addr == BASE_ADDR + CTRL_OFF) ctrl_d = cpu_data[2:0];
  end

  for (genvar k = 0; k < NUM_PULSE; k++) begin : g_pulse
    localparam logic [15:0] CH_BASE = BASE_ADDR + 16'(k) * CH_STRIDE;
    logic [15:0] off;
    logic        hit;
    assign off = cpu_addr - CH_BASE;
    assign hit = !cpu_rw && (off < REG_SPAN);
    snd_pulse_ch u_ch (
      .clk_i    (cpu_m2),
      .rst_i    (rst),
      .halt_i   (ctrl_q[CTRL_HALT]),
      .shift4_i (ctrl_q[CTRL_SHIFT4]),
      .shift8_i (ctrl_q[CTRL_SHIFT8]),
      .wr_i     (hit),
      .off_i    (off[1:0]),
      .data_i   (cpu_data),
      .level_o  (pulse_level[k])
    );
  end

  if (SAW_EN != 0) begin : g_saw
    logic [5:0]  rate_q, rate_d;
    logic [11:0] per_q, per_d;
    logic        en_q, en_d;
    logic [11:0] div_q, div_d;
    logic [2:0]  step_q, step_d, step_n;
    logic        par_q, par_d;
    logic [7:0]  acc_q, acc_d;
    logic [15:0] off;
    logic        hit;

    assign off = cpu_addr - SAW_BASE;
    assign hit = !cpu_rw && (off < REG_SPAN);

    always_comb begin
      rate_d = rate_q;
      per_d  = per_q;
      en_d   = en_q;
      div_d  = div_q;
      step_d = step_q;
      par_d  = par_q;
      acc_d  = acc_q;
      step_n = step_q + 3'd1;
      if (hit) begin
        case (off[1:0])
          REG0_OFF: rate_d = cpu_data[5:0];
          REG1_OFF: per_d[7:0] = cpu_data;
          REG2_OFF: begin
            per_d[11:8] = cpu_data[3:0];
            en_d        = cpu_data[7];
          end
          default: ;
        endcase
      end
      if (!en_q || !en_d) begin
        div_d  = eff_period(per_d, ctrl_q[CTRL_SHIFT4], ctrl_q[CTRL_SHIFT8]);
        step_d = '0;
        par_d  = 1'b0;
        acc_d  = '0;
      end else if (!ctrl_q[CTRL_HALT]) begin
        if (div_q == '0) begin
          div_d = eff_period(per_q, ctrl_q[CTRL_SHIFT4], ctrl_q[CTRL_SHIFT8]);
          par_d = !par_q;
          // Step 6 folds straight back to step 0, which restarts the ramp from zero.
          if (par_q) begin
            if (step_n == SAW_STEP_WRAP) begin
              step_d = '0;
              acc_d  = '0;
            end else begin
              step_d = step_n;
              acc_d  = acc_q + {2'b00, rate_q};
            end
          end
        end else begin
          div_d = div_q - 12'd1;
        end
      end
    end

    always_ff @(negedge cpu_m2) begin
      if (rst) begin
        rate_q <= '0;
        per_q  <= '0;
        en_q   <= 1'b0;
        div_q  <= '0;
        step_q <= '0;
        par_q  <= 1'b0;
        acc_q  <= '0;
      end else begin
        rate_q <= rate_d;
        per_q  <= per_d;
        en_q   <= en_d;
        div_q  <= div_d;
        step_q <= step_d;
        par_q  <= par_d;
        acc_q  <= acc_d;
      end
    end

    assign saw_level = en_q ? acc_q[7:3] : 5'd0;
  end else begin : g_no_saw
    assign saw_level = 5'd0;
  end

  always_comb begin
    sum = SUM_W'(saw_level);
    for (int k = 0; k < NUM_PULSE; k++) sum = sum + SUM_W'(pulse_level[k]);
  end

  assign vol_d = (32'(sum) > VOL_MAX) ? OUT_W'(VOL_MAX) : OUT_W'(sum);

  always_ff @(negedge cpu_m2) begin
    if (rst) begin
      ctrl_q <= '0;
      vol_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      vol_q  <= vol_d;
    end
  end

  assign snd_vol = vol_q;

endmodule

// File: tb/tb_snd_pulse_bank.sv
// tb/tb_snd_pulse_bank.sv - directed self-checking bench for snd_pulse_bank (default and OUT_W=5)
module tb_snd_pulse_bank;

  logic        cpu_m2 = 1'b1;
  logic        rst = 1'b1;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic [6:0]  snd_vol;
  logic [4:0]  snd_vol5;
  int          total = 0;
  int          bad = 0;

  snd_pulse_bank dut (
    .cpu_m2   (cpu_m2),
    .rst      (rst),
    .cpu_rw   (cpu_rw),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .snd_vol  (snd_vol)
  );

  snd_pulse_bank #(.OUT_W(5)) dut5 (
    .cpu_m2   (cpu_m2),
    .rst      (rst),
    .cpu_rw   (cpu_rw),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .snd_vol  (snd_vol5)
  );

  always #5 cpu_m2 = ~cpu_m2;

  // One bus cycle; the DUT captures it on the falling edge before the returning rising edge.
  task automatic cyc(input bit wr, input logic [15:0] a, input logic [7:0] d);
    cpu_rw   = !wr;
    cpu_addr = a;
    cpu_data = d;
    @(posedge cpu_m2);
    cpu_rw = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 16'h0000, 8'h00);
    rst = 1'b0;
  endtask

  function automatic int duty_exp(input int k);
    if (k < 2) return 0;
    return ((((k - 2) / 3) % 16) <= 3) ? 15 : 0;
  endfunction

  task automatic test_reset();
    rst      = 1'b1;
    cpu_rw   = 1'b0;
    cpu_addr = 16'h9000;
    cpu_data = 8'h8F;
    @(posedge cpu_m2);
    @(posedge cpu_m2);
    total++;
    if (snd_vol !== 7'd0 || snd_vol5 !== 5'd0) begin
      bad++;
      $display("FAIL reset_state snd_vol=%0d snd_vol5=%0d exp=0", snd_vol, snd_vol5);
    end
    rst    = 1'b0;
    cpu_rw = 1'b1;
    cyc(1'b1, 16'h9002, 8'h80);
    for (int j = 1; j <= 4; j++) begin
      cyc(1'b0, 16'h0000, 8'h00);
      total++;
      if (snd_vol !== 7'd0 || snd_vol5 !== 5'd0) begin
        bad++;
        $display("FAIL reset_priority j=%0d snd_vol=%0d snd_vol5=%0d exp=0", j, snd_vol, snd_vol5);
      end
    end
  endtask

  task automatic test_duty_pattern();
    int e;
    do_reset();
    cyc(1'b1, 16'h9000, 8'h3F);
    cyc(1'b1, 16'h9001, 8'h02);
    cyc(1'b1, 16'h9002, 8'h80);
    for (int j = 1; j <= 100; j++) begin
      cyc(1'b0, 16'h0000, 8'h00);
      e = duty_exp(j);
      total++;
      if (snd_vol !== 7'(e) || snd_vol5 !== 5'(e)) begin
        bad++;
        $display("FAIL duty_pattern j=%0d snd_vol=%0d snd_vol5=%0d exp=%0d", j, snd_vol, snd_vol5, e);
      end
    end
  endtask

  task automatic test_mode_const();
    int exp_seq [6] = '{0, 0, 10, 10, 10, 10};
    int upd_seq [3] = '{10, 10, 5};
    do_reset();
    cyc(1'b1, 16'h9000, 8'h8A);
    cyc(1'b1, 16'h9002, 8'h80);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) cyc(1'b0, 16'h0000, 8'h00);
      total++;
      if (snd_vol !== 7'(exp_seq[j]) || snd_vol5 !== 5'(exp_seq[j])) begin
        bad++;
        $display("FAIL mode_const j=%0d snd_vol=%0d snd_vol5=%0d exp=%0d", j, snd_vol, snd_vol5, exp_seq[j]);
      end
    end
    cyc(1'b1, 16'h9000, 8'h85);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) cyc(1'b0, 16'h0000, 8'h00);
      total++;
      if (snd_vol !== 7'(upd_seq[j]) || snd_vol5 !== 5'(upd_seq[j])) begin
        bad++;
        $display("FAIL vol_update j=%0d snd_vol=%0d snd_vol5=%0d exp=%0d", j, snd_vol, snd_vol5, upd_seq[j]);
      end
    end
  endtask

  task automatic test_saw();
    int sv [6] = '{0, 1, 2, 3, 5, 6};
    int e;
    do_reset();
    cyc(1'b1, 16'hB000, 8'h0A);
    cyc(1'b1, 16'hB002, 8'h80);
    for (int j = 1; j <= 26; j++) begin
      cyc(1'b0, 16'h0000, 8'h00);
      e = sv[((j - 1) / 2) % 6];
      total++;
      if (snd_vol !== 7'(e) || snd_vol5 !== 5'(e)) begin
        bad++;
        $display("FAIL saw_ramp j=%0d snd_vol=%0d snd_vol5=%0d exp=%0d", j, snd_vol, snd_vol5, e);
      end
    end
  endtask

  // Halt is written at E+6 and cleared at E+56, so the channel loses exactly 50 running clocks.
  task automatic test_halt();
    int r;
    int e;
    do_reset();
    cyc(1'b1, 16'h9003, 8'h02);
    cyc(1'b1, 16'h9000, 8'h0F);
    cyc(1'b1, 16'h9002, 8'h81);
    for (int j = 1; j <= 330; j++) begin
      if (j == 6)       cyc(1'b1, 16'h9003, 8'h03);
      else if (j == 56) cyc(1'b1, 16'h9003, 8'h02);
      else              cyc(1'b0, 16'h0000, 8'h00);
      if (j < 2) e = 0;
      else begin
        r = (j - 2 <= 6) ? j - 2 : ((j - 2 <= 56) ? 6 : j - 2 - 50);
        e = (((r / 17) % 16) == 0) ? 15 : 0;
      end
      total++;
      if (snd_vol !== 7'(e) || snd_vol5 !== 5'(e)) begin
        bad++;
        $display("FAIL halt_phase j=%0d snd_vol=%0d snd_vol5=%0d exp=%0d", j, snd_vol, snd_vol5, e);
      end
    end
  endtask

  task automatic test_restart();
    int e;
    do_reset();
    cyc(1'b1, 16'h9000, 8'h3F);
    cyc(1'b1, 16'h9001, 8'h02);
    cyc(1'b1, 16'h9002, 8'h80);
    for (int j = 1; j <= 19; j++) cyc(1'b0, 16'h0000, 8'h00);
    cyc(1'b1, 16'h9002, 8'h00);
    cyc(1'b0, 16'h0000, 8'h00);
    cyc(1'b1, 16'h9002, 8'h80);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 16'h0000, 8'h00);
      e = duty_exp(k);
      total++;
      if (snd_vol !== 7'(e) || snd_vol5 !== 5'(e)) begin
        bad++;
        $display("FAIL reenable k=%0d snd_vol=%0d snd_vol5=%0d exp=%0d", k, snd_vol, snd_vol5, e);
      end
    end
    for (int k = 1; k <= 5; k++) cyc(1'b0, 16'h0000, 8'h00);
    rst = 1'b1;
    cyc(1'b0, 16'h0000, 8'h00);
    rst = 1'b0;
    total++;
    if (snd_vol !== 7'd0 || snd_vol5 !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset snd_vol=%0d snd_vol5=%0d exp=0", snd_vol, snd_vol5);
    end
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 16'h0000, 8'h00);
      total++;
      if (snd_vol !== 7'd0 || snd_vol5 !== 5'd0) begin
        bad++;
        $display("FAIL post_reset_idle k=%0d snd_vol=%0d snd_vol5=%0d exp=0", k, snd_vol, snd_vol5);
      end
    end
    cyc(1'b1, 16'h9000, 8'h3F);
    cyc(1'b1, 16'h9001, 8'h02);
    cyc(1'b1, 16'h9002, 8'h80);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 16'h0000, 8'h00);
      e = duty_exp(k);
      total++;
      if (snd_vol !== 7'(e) || snd_vol5 !== 5'(e)) begin
        bad++;
        $display("FAIL post_reset_run k=%0d snd_vol=%0d snd_vol5=%0d exp=%0d", k, snd_vol, snd_vol5, e);
      end
    end
  endtask

  task automatic test_saturate();
    int sl [6] = '{0, 7, 15, 23, 31, 7};
    int e;
    int e5;
    do_reset();
    cyc(1'b1, 16'h9000, 8'h8F);
    cyc(1'b1, 16'h9002, 8'h80);
    cyc(1'b1, 16'hA000, 8'h8F);
    cyc(1'b1, 16'hA002, 8'h80);
    cyc(1'b1, 16'hB000, 8'h3F);
    cyc(1'b1, 16'hB002, 8'h80);
    for (int j = 1; j <= 14; j++) begin
      cyc(1'b0, 16'h0000, 8'h00);
      e  = 30 + sl[((j - 1) / 2) % 6];
      e5 = (e > 31) ? 31 : e;
      total++;
      if (snd_vol !== 7'(e) || snd_vol5 !== 5'(e5)) begin
        bad++;
        $display("FAIL saturate j=%0d snd_vol=%0d exp=%0d snd_vol5=%0d exp5=%0d", j, snd_vol, e, snd_vol5, e5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty_pattern();
    test_mode_const();
    test_saw();
    test_halt();
    test_restart();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
